// File: rtl/if_fetch_queue.sv
// Instruction-fetch stage with an in-order prefetch queue over a req/ready + rvalid memory port.
// Credits bound (buffered + outstanding) fetches to DEPTH; redirects drop stale responses by count.
module if_fetch_queue #(
    parameter int              ADDR_W    = 32,
    parameter int              IM_ADDR_W = 14,
    parameter int              DEPTH     = 4,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_W-1:0]       EXE_jumpBranchAddr,
    input  logic                    EXE_jumpBranch,
    input  logic                    ID_hazardStall,
    output logic                    im_req,
    output logic [IM_ADDR_W-1:0]    im_addr,
    input  logic                    im_ready,
    input  logic                    im_rvalid,
    input  logic [31:0]             im_rdata,
    output logic [31:0]             instruction,
    output logic [ADDR_W-1:0]       pc_reg,
    output logic                    fetch_valid,
    output logic [$clog2(DEPTH):0]  queue_count,
    output logic                    fetch_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CW    = PTR_W + 1;
    localparam logic [CW:0] CREDITS = (CW + 1)'(DEPTH);

    logic [ADDR_W-1:0] r_fetch_pc;
    logic [ADDR_W-1:0] r_resp_pc;
    logic [31:0]       r_q_instr [DEPTH];
    logic [ADDR_W-1:0] r_q_pc    [DEPTH];
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [CW-1:0]     r_count;
    logic [CW-1:0]     r_outstanding;
    logic [CW-1:0]     r_drop_cnt;
    logic [31:0]       r_instruction;
    logic [ADDR_W-1:0] r_pc;
    logic              r_valid;
    logic              r_err;

    logic [CW:0] w_credit_used;
    logic        w_req;
    logic        w_accept;
    logic        w_resp;
    logic        w_spur;
    logic        w_live;
    logic        w_pop;
    logic        w_bypass;
    logic        w_enq;

    assign w_credit_used = {1'b0, r_count} + {1'b0, r_outstanding};
    // Request is held low in reset and in the redirect cycle; the target issues one cycle later.
    assign w_req    = !rst && !EXE_jumpBranch && (w_credit_used < CREDITS);
    assign w_accept = w_req && im_ready;
    assign w_resp   = im_rvalid && (r_outstanding != '0);
    assign w_spur   = im_rvalid && (r_outstanding == '0);
    assign w_live   = w_resp && (r_drop_cnt == '0) && !EXE_jumpBranch;
    assign w_pop    = !EXE_jumpBranch && !ID_hazardStall && (r_count != '0);
    assign w_bypass = w_live && !ID_hazardStall && (r_count == '0);
    assign w_enq    = w_live && !w_bypass;

    // NOTE: queue storage has no reset; r_count alone decides which entries are meaningful.
    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_q_instr[r_wr_ptr] <= im_rdata;
            r_q_pc[r_wr_ptr]    <= r_resp_pc;
        end
    end

    // NOTE: every register here uses <= so all updates see the same pre-edge state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_pc    <= RESET_PC;
            r_resp_pc     <= RESET_PC;
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
            r_count       <= '0;
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
            r_instruction <= '0;
            r_pc          <= '0;
            r_valid       <= 1'b0;
            r_err         <= 1'b0;
        end else begin
            if (w_spur) begin
                r_err <= 1'b1;
            end
            if (w_accept && !w_resp) begin
                r_outstanding <= r_outstanding + CW'(1);
            end else if (!w_accept && w_resp) begin
                r_outstanding <= r_outstanding - CW'(1);
            end
            if (w_accept) begin
                r_fetch_pc <= r_fetch_pc + ADDR_W'(4);
            end

            if (EXE_jumpBranch) begin
                r_fetch_pc    <= EXE_jumpBranchAddr;
                r_resp_pc     <= EXE_jumpBranchAddr;
                r_rd_ptr      <= '0;
                r_wr_ptr      <= '0;
                r_count       <= '0;
                // Everything still in flight after this cycle belongs to the old path.
                r_drop_cnt    <= r_outstanding - CW'(w_resp);
                r_instruction <= '0;
                r_pc          <= '0;
                r_valid       <= 1'b0;
            end else begin
                if (w_resp && (r_drop_cnt != '0)) begin
                    r_drop_cnt <= r_drop_cnt - CW'(1);
                end
                if (w_live) begin
                    r_resp_pc <= r_resp_pc + ADDR_W'(4);
                end
                if (w_enq) begin
                    r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                end
                if (w_enq && !w_pop) begin
                    r_count <= r_count + CW'(1);
                end else if (!w_enq && w_pop) begin
                    r_count <= r_count - CW'(1);
                end

                if (!ID_hazardStall) begin
                    if (w_pop) begin
                        r_instruction <= r_q_instr[r_rd_ptr];
                        r_pc          <= r_q_pc[r_rd_ptr];
                        r_valid       <= 1'b1;
                    end else if (w_bypass) begin
                        r_instruction <= im_rdata;
                        r_pc          <= r_resp_pc;
                        r_valid       <= 1'b1;
                    end else begin
                        r_instruction <= '0;
                        r_pc          <= '0;
                        r_valid       <= 1'b0;
                    end
                end
            end
        end
    end

    assign im_req      = w_req;
    assign im_addr     = r_fetch_pc[IM_ADDR_W+1:2];
    assign instruction = r_instruction;
    assign pc_reg      = r_pc;
    assign fetch_valid = r_valid;
    assign queue_count = r_count;
    assign fetch_err   = r_err;

endmodule
